// File: rtl/switch_arbiter.sv
// Round-robin switch allocator for a 5-port mesh router with wormhole locking.
// Each output keeps its owner while the owner still requests it, else re-arbitrates in the same edge.
module switch_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] request_L,
  input  logic [2:0] request_N,
  input  logic [2:0] request_E,
  input  logic [2:0] request_S,
  input  logic [2:0] request_W,
  output logic       grant_L,
  output logic       grant_N,
  output logic       grant_E,
  output logic       grant_S,
  output logic       grant_W,
  output logic [2:0] select_L,
  output logic [2:0] select_N,
  output logic [2:0] select_E,
  output logic [2:0] select_S,
  output logic [2:0] select_W
);

  localparam int         NP   = 5;
  localparam logic [2:0] IDLE = 3'b111;

  logic [2:0]    req      [NP];
  logic [NP-1:0] hits     [NP];
  logic [2:0]    pick     [NP];
  logic [NP-1:0] keep;

  logic [NP-1:0] own_vld;
  logic [2:0]    own_idx  [NP];
  logic [2:0]    ptr      [NP];

  logic [NP-1:0] nxt_vld;
  logic [2:0]    nxt_idx  [NP];
  logic [2:0]    nxt_ptr  [NP];
  logic [NP-1:0] nxt_grant;

  logic [NP-1:0] grant_q;
  logic [2:0]    sel_q    [NP];

  // First requester found scanning cyclically from start; IDLE when nobody asks.
  function automatic logic [2:0] rr_pick(input logic [NP-1:0] h, input logic [2:0] start);
    logic [2:0] p;
    int         idx;
    p = IDLE;
    for (int k = NP - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NP;
      if (h[idx]) p = 3'(idx);
    end
    return p;
  endfunction

  function automatic logic [2:0] inc_mod(input logic [2:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  assign req[0] = request_L;
  assign req[1] = request_N;
  assign req[2] = request_E;
  assign req[3] = request_S;
  assign req[4] = request_W;

  always_comb begin
    for (int y = 0; y < NP; y++) begin
      hits[y] = '0;
      for (int x = 0; x < NP; x++) begin
        hits[y][x] = (req[x] == 3'(y));
      end
      keep[y] = own_vld[y] && hits[y][own_idx[y]];
      pick[y] = rr_pick(hits[y], ptr[y]);
    end
  end

  always_comb begin
    nxt_vld   = '0;
    nxt_grant = '0;
    for (int y = 0; y < NP; y++) begin
      nxt_idx[y] = own_idx[y];
      nxt_ptr[y] = ptr[y];
      if (keep[y]) begin
        nxt_vld[y] = 1'b1;
      end else if (pick[y] != IDLE) begin
        nxt_vld[y] = 1'b1;
        nxt_idx[y] = pick[y];
        nxt_ptr[y] = inc_mod(pick[y]);
      end
    end
    // An owner always requests its output at the edge it is (re)confirmed.
    for (int x = 0; x < NP; x++) begin
      for (int y = 0; y < NP; y++) begin
        if (nxt_vld[y] && nxt_idx[y] == 3'(x)) nxt_grant[x] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_vld <= '0;
      grant_q <= '0;
      for (int y = 0; y < NP; y++) begin
        own_idx[y] <= '0;
        ptr[y]     <= '0;
        sel_q[y]   <= IDLE;
      end
    end else begin
      own_vld <= nxt_vld;
      grant_q <= nxt_grant;
      for (int y = 0; y < NP; y++) begin
        own_idx[y] <= nxt_idx[y];
        ptr[y]     <= nxt_ptr[y];
        sel_q[y]   <= nxt_vld[y] ? nxt_idx[y] : IDLE;
      end
    end
  end

  assign grant_L  = grant_q[0];
  assign grant_N  = grant_q[1];
  assign grant_E  = grant_q[2];
  assign grant_S  = grant_q[3];
  assign grant_W  = grant_q[4];
  assign select_L = sel_q[0];
  assign select_N = sel_q[1];
  assign select_E = sel_q[2];
  assign select_S = sel_q[3];
  assign select_W = sel_q[4];

endmodule

// File: tb/tb_switch_arbiter.sv
// Directed scoreboard bench for switch_arbiter: expectations queued at drive time, checked after the edge.
module tb_switch_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] request_L, request_N, request_E, request_S, request_W;
  logic       grant_L, grant_N, grant_E, grant_S, grant_W;
  logic [2:0] select_L, select_N, select_E, select_S, select_W;

  typedef struct {
    string      tag;
    logic [4:0] g;
    logic [14:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run;
  int   tests_failed;

  switch_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .request_L (request_L),
    .request_N (request_N),
    .request_E (request_E),
    .request_S (request_S),
    .request_W (request_W),
    .grant_L   (grant_L),
    .grant_N   (grant_N),
    .grant_E   (grant_E),
    .grant_S   (grant_S),
    .grant_W   (grant_W),
    .select_L  (select_L),
    .select_N  (select_N),
    .select_E  (select_E),
    .select_S  (select_S),
    .select_W  (select_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed views ordered {W,S,E,N,L}.
  function automatic logic [14:0] sel5(input logic [2:0] l, input logic [2:0] n,
                                       input logic [2:0] e, input logic [2:0] s,
                                       input logic [2:0] w);
    return {w, s, e, n, l};
  endfunction

  task automatic set_req(input logic [2:0] l, input logic [2:0] n, input logic [2:0] e,
                         input logic [2:0] s, input logic [2:0] w);
    request_L = l; request_N = n; request_E = e; request_S = s; request_W = w;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] g, input logic [14:0] s);
    exp_t e;
    e.tag = tag; e.g = g; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [4:0]  g_obs;
    logic [14:0] s_obs;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL scoreboard_empty observed=empty required=entry");
      return;
    end
    e     = exp_q.pop_front();
    g_obs = {grant_W, grant_S, grant_E, grant_N, grant_L};
    s_obs = {select_W, select_S, select_E, select_N, select_L};
    tests_run++;
    assert (g_obs === e.g) else begin
      tests_failed++;
      $error("FAIL %s grants observed=%b required=%b", e.tag, g_obs, e.g);
    end
    tests_run++;
    assert (s_obs === e.s) else begin
      tests_failed++;
      $error("FAIL %s selects observed=%h required=%h", e.tag, s_obs, e.s);
    end
  endtask

  // Drive on the falling edge, check 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic [2:0] l, input logic [2:0] n,
                      input logic [2:0] e, input logic [2:0] s, input logic [2:0] w,
                      input logic [4:0] g, input logic [14:0] sel);
    @(negedge clk);
    set_req(l, n, e, s, w);
    expect_out(tag, g, sel);
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_req(7, 7, 7, 7, 7);
    @(negedge clk);
    rst = 1'b1;
  endtask

  localparam logic [14:0] ALL_IDLE = {5{3'b111}};

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0;
    set_req(7, 7, 7, 7, 7);

    // Reset held low: outputs idle, even across edges.
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_hold", 5'b00000, ALL_IDLE);
    check_now();

    @(negedge clk);
    rst = 1'b1;
    step("reset_release", 7, 7, 7, 7, 7, 5'b00000, ALL_IDLE);

    // Single request W->L, then E contends and waits on the lock.
    step("single_W_to_L", 7, 7, 7, 7, 0, 5'b10000, sel5(4, 7, 7, 7, 7));
    step("lock_E_waits_1", 7, 7, 0, 7, 0, 5'b10000, sel5(4, 7, 7, 7, 7));
    step("lock_E_waits_2", 7, 7, 0, 7, 0, 5'b10000, sel5(4, 7, 7, 7, 7));
    step("handover_to_E", 7, 7, 0, 7, 7, 5'b00100, sel5(2, 7, 7, 7, 7));
    step("release_all", 7, 7, 7, 7, 7, 5'b00000, ALL_IDLE);

    // Round-robin on output E from fresh pointers.
    do_reset();
    step("rr_N_first", 7, 2, 7, 2, 7, 5'b00010, sel5(7, 7, 1, 7, 7));
    step("rr_S_takes", 7, 7, 7, 2, 7, 5'b01000, sel5(7, 7, 3, 7, 7));
    step("rr_S_keeps", 7, 2, 7, 2, 7, 5'b01000, sel5(7, 7, 3, 7, 7));
    step("rr_N_regains", 7, 2, 7, 7, 7, 5'b00010, sel5(7, 7, 1, 7, 7));
    step("rr_idle", 7, 7, 7, 7, 7, 5'b00000, ALL_IDLE);
    // Pointer now past N, so a fresh tie goes to S.
    step("rr_tie_S_wins", 7, 2, 7, 2, 7, 5'b01000, sel5(7, 7, 3, 7, 7));
    step("rr_idle_2", 7, 7, 7, 7, 7, 5'b00000, ALL_IDLE);

    // Codes 5 and 6 are ignored; self-direction is legal.
    step("ignore_codes", 5, 6, 5, 6, 7, 5'b00000, ALL_IDLE);
    step("self_L_to_L", 0, 7, 7, 7, 7, 5'b00001, sel5(0, 7, 7, 7, 7));

    // All five outputs in parallel, then asynchronous reset mid-cycle.
    step("parallel", 1, 3, 4, 0, 2, 5'b11111, sel5(3, 0, 4, 1, 2));
    step("parallel_hold", 1, 3, 4, 0, 2, 5'b11111, sel5(3, 0, 4, 1, 2));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    expect_out("async_reset", 5'b00000, ALL_IDLE);
    check_now();
    @(posedge clk);
    #1;
    expect_out("async_reset_edge", 5'b00000, ALL_IDLE);
    check_now();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_out("post_reset_rearb", 5'b11111, sel5(3, 0, 4, 1, 2));
    check_now();

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
